// File: rtl/mc10_tape_player_if.sv
`default_nettype none
// mc10_tape_player_if: loader-side handshake and cassette outputs of the MC-10 tape player.
// Rev 1.0
interface mc10_tape_player_if;
  logic       play;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       cin;
  logic       busy;
  logic       underrun;

  modport master (
    output play, byte_in, byte_valid,
    input  byte_ready, cin, busy, underrun
  );

  modport slave (
    input  play, byte_in, byte_valid,
    output byte_ready, cin, busy, underrun
  );
endinterface
`default_nettype wire

// File: rtl/mc10_tape_player.sv
`default_nettype none
// mc10_tape_player: serialises tape bytes LSB-first into MC-10 FSK (1 = 2400 Hz cycle, 0 = 1200 Hz).
// Rev 1.0 -- optional TAPE_LEADER_EN: fill starvation gaps with 0x55 leader bytes.
module mc10_tape_player #(
  parameter int HALF_0 = 11932,
  parameter int HALF_1 = 5966,
  parameter int CNT_W  = 16
) (
  input  logic               clk_sys,
  input  logic               reset,
  mc10_tape_player_if.slave  tp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               underrun_q, underrun_d;

  logic               w_accept;
  logic               w_load_hold;
  logic               w_load_leader;
  logic [7:0]         w_next_byte;

  function automatic logic [CNT_W-1:0] half_reload(input logic b);
    return b ? CNT_W'(HALF_1 - 1) : CNT_W'(HALF_0 - 1);
  endfunction

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    underrun_d    = 1'b0;
    w_load_hold   = 1'b0;
    w_load_leader = 1'b0;
    w_next_byte   = hold_q;

    // A move out of hold needs hold_full, so it can never coincide with an accept.
    w_accept = tp.byte_valid & ~hold_full_q;
    if (w_accept) begin
      hold_d      = tp.byte_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tp.play && hold_full_q) begin
          w_load_hold = 1'b1;
        end
`ifdef TAPE_LEADER_EN
        else if (tp.play) begin
          w_load_leader = 1'b1;
        end
`endif
      end
      S_HI: begin
        if (cnt_q == '0) begin
          state_d = S_LO;
          cnt_d   = half_reload(shift_q[0]);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LO: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q != 3'd7) begin
          idx_d   = idx_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = half_reload(shift_q[1]);
          state_d = S_HI;
        end else if (tp.play && hold_full_q) begin
          w_load_hold = 1'b1;
        end else if (!tp.play) begin
          state_d = S_IDLE;
        end else begin
          underrun_d = 1'b1;
`ifdef TAPE_LEADER_EN
          w_load_leader = 1'b1;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_load_hold || w_load_leader) begin
      w_next_byte = w_load_hold ? hold_q : 8'h55;
      shift_d     = w_next_byte;
      idx_d       = 3'd0;
      cnt_d       = half_reload(w_next_byte[0]);
      state_d     = S_HI;
      if (w_load_hold) begin
        hold_full_d = 1'b0;
      end
    end
  end

  assign tp.cin        = (state_q == S_HI);
  assign tp.busy       = (state_q != S_IDLE);
  assign tp.underrun   = underrun_q;
  assign tp.byte_ready = ~hold_full_q;

endmodule
`default_nettype wire
